// File: rtl/fmap_bram_reader_pkg.sv
// Shared constants and types for the feature-map BRAM read-side sequencer.
package fmap_pkg;

  localparam int NUM_BANK = 16;
  localparam int ADDR_W   = 9;
  localparam int DATA_W   = 128;
  localparam int BANK_W   = $clog2(NUM_BANK);

  typedef struct packed {
    logic [BANK_W-1:0] bank;
    logic [ADDR_W-1:0] addr;
    logic              last;
  } tag_t;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_ISSUE,
    ST_DRAIN,
    ST_DONE
  } rd_state_t;

endpackage

// File: rtl/fmap_bram_reader_sync_fifo_tagged.sv
// Small synchronous FIFO with occupancy count; holds read data plus its tag.
module sync_fifo_tagged #(
  parameter int DEPTH = 4,
  parameter int WIDTH = 8,
  parameter int CNT_W = $clog2(DEPTH + 1)
) (
  input  logic             clk,
  input  logic             rstn,
  input  logic             i_push,
  input  logic [WIDTH-1:0] i_data,
  input  logic             i_pop,
  output logic [WIDTH-1:0] o_data,
  output logic             o_empty,
  output logic [CNT_W-1:0] o_count
);

  localparam int PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;

  logic [WIDTH-1:0] r_mem [DEPTH];
  logic [PTR_W-1:0] r_wr_ptr;
  logic [PTR_W-1:0] r_rd_ptr;
  logic [CNT_W-1:0] r_count;
  logic             w_full;
  logic             w_do_push;
  logic             w_do_pop;

  assign o_empty   = (r_count == '0);
  assign w_full    = (r_count == CNT_W'(DEPTH));
  assign w_do_pop  = i_pop && !o_empty;
  // A push into a full FIFO is accepted only when a pop frees the slot this cycle.
  assign w_do_push = i_push && (!w_full || w_do_pop);
  assign o_data    = r_mem[r_rd_ptr];
  assign o_count   = r_count;

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      for (int unsigned i = 0; i < DEPTH; i++) begin
        r_mem[i] <= '0;
      end
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_count  <= '0;
    end else begin
      if (w_do_push) begin
        r_mem[r_wr_ptr] <= i_data;
        r_wr_ptr        <= (r_wr_ptr == PTR_W'(DEPTH - 1)) ? '0 : r_wr_ptr + PTR_W'(1);
      end
      if (w_do_pop) begin
        r_rd_ptr <= (r_rd_ptr == PTR_W'(DEPTH - 1)) ? '0 : r_rd_ptr + PTR_W'(1);
      end
      r_count <= r_count + CNT_W'(w_do_push) - CNT_W'(w_do_pop);
    end
  end

endmodule

// File: rtl/fmap_bram_reader.sv
// Walks all banks/addresses of the feature-map BRAM through port B and streams
// tagged 128-bit words to the datapath over a valid/ready handshake.
module fmap_bram_reader #(
  parameter int NUM_BANK   = fmap_pkg::NUM_BANK,
  parameter int ADDR_W     = fmap_pkg::ADDR_W,
  parameter int NUM_WORDS  = 128,
  parameter int DATA_W     = fmap_pkg::DATA_W,
  parameter int READ_LAT   = 1,
  parameter int FIFO_DEPTH = 4
) (
  input  logic                clk,
  input  logic                rstn,
  input  logic                iStart,
  output logic [NUM_BANK-1:0] o_enb,
  output logic [ADDR_W-1:0]   o_addrb,
  input  logic [DATA_W-1:0]   i_dob,
  output logic [DATA_W-1:0]   oData,
  output logic [3:0]          oBank,
  output logic [ADDR_W-1:0]   oAddr,
  output logic                oLast,
  output logic                oValid,
  input  logic                iReady,
  output logic                oBusy,
  output logic                oDone
);

  import fmap_pkg::*;

  typedef struct packed {
    logic [3:0]        bank;
    logic [ADDR_W-1:0] addr;
    logic              last;
  } rd_tag_t;

  localparam int TAG_W = $bits(rd_tag_t);
  localparam int CNT_W = $clog2(FIFO_DEPTH + 1);
  localparam int INF_W = $clog2(READ_LAT + 2);

  rd_state_t           r_state;
  logic [3:0]          r_bank_cnt;
  logic [ADDR_W-1:0]   r_addr_cnt;
  logic [READ_LAT:0]   r_pipe_v;
  rd_tag_t             r_pipe_tag [READ_LAT+1];

  logic [INF_W-1:0]        w_inflight;
  logic [CNT_W-1:0]        w_fifo_count;
  logic                    w_fifo_empty;
  logic                    w_pop;
  logic                    w_credit_ok;
  logic                    w_issue;
  logic                    w_addr_wrap;
  logic                    w_last_rd;
  logic                    w_drain_done;
  rd_tag_t                 w_cur_tag;
  rd_tag_t                 w_head_tag;
  logic [DATA_W+TAG_W-1:0] w_push_data;
  logic [DATA_W+TAG_W-1:0] w_head;

  always_comb begin
    w_inflight = '0;
    for (int unsigned i = 0; i <= READ_LAT; i++) begin
      w_inflight = w_inflight + INF_W'(r_pipe_v[i]);
    end
  end

  assign w_pop       = oValid && iReady;
  // Credit covers words already buffered plus reads still in the BRAM pipe.
  assign w_credit_ok = (32'(w_fifo_count) + 32'(w_inflight)) < (32'(FIFO_DEPTH) + 32'(w_pop));
  assign w_issue     = ((r_state == ST_ISSUE) || ((r_state == ST_IDLE) && iStart)) && w_credit_ok;
  assign w_addr_wrap = (r_addr_cnt == ADDR_W'(NUM_WORDS - 1));
  assign w_last_rd   = w_addr_wrap && (r_bank_cnt == 4'(NUM_BANK - 1));
  assign w_cur_tag   = '{bank: r_bank_cnt, addr: r_addr_cnt, last: w_last_rd};

  // Done is flagged on the edge that pops the final word, so oDone follows it directly.
  assign w_drain_done = (w_inflight == '0) &&
                        ((w_fifo_count == '0) || ((w_fifo_count == CNT_W'(1)) && w_pop));

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      r_pipe_v <= '0;
      for (int unsigned i = 0; i <= READ_LAT; i++) begin
        r_pipe_tag[i] <= '0;
      end
    end else begin
      r_pipe_v[0]   <= w_issue;
      r_pipe_tag[0] <= w_cur_tag;
      for (int unsigned i = 1; i <= READ_LAT; i++) begin
        r_pipe_v[i]   <= r_pipe_v[i-1];
        r_pipe_tag[i] <= r_pipe_tag[i-1];
      end
    end
  end

  assign w_push_data = {i_dob, r_pipe_tag[READ_LAT]};

  sync_fifo_tagged #(
    .DEPTH (FIFO_DEPTH),
    .WIDTH (DATA_W + TAG_W)
  ) u_out_fifo (
    .clk     (clk),
    .rstn    (rstn),
    .i_push  (r_pipe_v[READ_LAT]),
    .i_data  (w_push_data),
    .i_pop   (w_pop),
    .o_data  (w_head),
    .o_empty (w_fifo_empty),
    .o_count (w_fifo_count)
  );

  assign w_head_tag = w_head[TAG_W-1:0];
  assign oData      = w_head[TAG_W +: DATA_W];
  assign oBank      = w_head_tag.bank;
  assign oAddr      = w_head_tag.addr;
  assign oLast      = w_head_tag.last;
  assign oValid     = !w_fifo_empty;

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      r_state    <= ST_IDLE;
      o_enb      <= '0;
      o_addrb    <= '0;
      r_bank_cnt <= '0;
      r_addr_cnt <= '0;
      oBusy      <= 1'b0;
      oDone      <= 1'b0;
    end else begin
      oDone <= 1'b0;
      o_enb <= '0;
      if (w_issue) begin
        o_enb   <= NUM_BANK'(1) << r_bank_cnt;
        o_addrb <= r_addr_cnt;
        if (w_last_rd) begin
          r_bank_cnt <= '0;
          r_addr_cnt <= '0;
        end else if (w_addr_wrap) begin
          r_bank_cnt <= r_bank_cnt + 4'd1;
          r_addr_cnt <= '0;
        end else begin
          r_addr_cnt <= r_addr_cnt + ADDR_W'(1);
        end
      end
      case (r_state)
        ST_IDLE: begin
          if (w_issue) begin
            oBusy   <= 1'b1;
            r_state <= w_last_rd ? ST_DRAIN : ST_ISSUE;
          end
        end
        ST_ISSUE: begin
          if (w_issue && w_last_rd) begin
            r_state <= ST_DRAIN;
          end
        end
        ST_DRAIN: begin
          if (w_drain_done) begin
            oDone   <= 1'b1;
            oBusy   <= 1'b0;
            r_state <= ST_DONE;
          end
        end
        ST_DONE: begin
          r_state <= ST_IDLE;
        end
        default: begin
          r_state <= ST_IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_fmap_bram_reader.sv
// Directed self-checking bench for fmap_bram_reader (default and small configs).
module tb_fmap_bram_reader;

  localparam int NW    = 128;
  localparam int NB    = 16;
  localparam int TOTAL = NB * NW;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic         rstn;
  logic         iStart, iReady;
  logic [15:0]  o_enb;
  logic [8:0]   o_addrb;
  logic [127:0] i_dob = '0;
  logic [127:0] oData;
  logic [3:0]   oBank;
  logic [8:0]   oAddr;
  logic         oLast, oValid, oBusy, oDone;

  logic         iStart2, iReady2;
  logic [1:0]   o_enb2;
  logic [8:0]   o_addrb2;
  logic [127:0] i_dob2 = '0;
  logic [127:0] r_s1 = '0;
  logic [127:0] oData2;
  logic [3:0]   oBank2;
  logic [8:0]   oAddr2;
  logic         oLast2, oValid2, oBusy2, oDone2;

  int checks = 0;
  int failures = 0;
  int mode = 0;
  int issued = 0;
  int hs = 0;
  int max_out = 0;
  int done_cnt = 0;

  fmap_bram_reader u_dut (
    .clk(clk), .rstn(rstn), .iStart(iStart), .o_enb(o_enb), .o_addrb(o_addrb),
    .i_dob(i_dob), .oData(oData), .oBank(oBank), .oAddr(oAddr), .oLast(oLast),
    .oValid(oValid), .iReady(iReady), .oBusy(oBusy), .oDone(oDone)
  );

  fmap_bram_reader #(.NUM_BANK(2), .NUM_WORDS(1), .READ_LAT(2)) u_dut2 (
    .clk(clk), .rstn(rstn), .iStart(iStart2), .o_enb(o_enb2), .o_addrb(o_addrb2),
    .i_dob(i_dob2), .oData(oData2), .oBank(oBank2), .oAddr(oAddr2), .oLast(oLast2),
    .oValid(oValid2), .iReady(iReady2), .oBusy(oBusy2), .oDone(oDone2)
  );

  function automatic logic [127:0] word_of(input int m, input int b, input int a);
    logic [127:0] w;
    w = '0;
    if (m == 0) begin
      for (int i = 0; i < 16; i++) w[i*8 +: 8] = {4'(i), 4'(b)};
    end else begin
      for (int i = 0; i < 8; i++) w[i*16 +: 16] = {4'(b), 3'b000, 9'(a)};
    end
    return w;
  endfunction

  function automatic int bank_of(input logic [15:0] e);
    int r;
    r = -1;
    for (int i = 0; i < 16; i++) if (e == (16'd1 << i)) r = i;
    return r;
  endfunction

  // BRAM models: one-cycle latency for u_dut, two-cycle for u_dut2.
  always @(posedge clk) begin
    if (o_enb != '0)
      i_dob <= (bank_of(o_enb) < 0) ? '1 : word_of(mode, bank_of(o_enb), int'(o_addrb));
  end

  always @(posedge clk) begin
    if (o_enb2 != '0)
      r_s1 <= (bank_of({14'b0, o_enb2}) < 0) ? '1 : word_of(mode, bank_of({14'b0, o_enb2}), int'(o_addrb2));
    i_dob2 <= r_s1;
  end

  // Outstanding reads = issued minus popped, checked before counting this cycle's pop.
  always @(negedge clk or negedge rstn) begin
    if (!rstn) begin
      issued <= 0;
      hs     <= 0;
    end else begin
      if (issued + int'(o_enb != '0) - hs > max_out) max_out <= issued + int'(o_enb != '0) - hs;
      issued <= issued + int'(o_enb != '0);
      hs     <= hs + int'(oValid && iReady);
    end
  end

  always @(posedge clk) if (oDone) done_cnt <= done_cnt + 1;

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached checks=%0d", checks);
    $fatal(1, "watchdog expired");
  end

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [159:0] obs, input logic [159:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic run_stream(input int ready_mode, input int stop_at, input int repulse_at,
                            output int got, output int cyc);
    got = 0;
    cyc = 0;
    while (got < stop_at && cyc < 20000) begin
      iReady = (ready_mode == 0) ? 1'b1 : 1'($urandom_range(0, 1));
      iStart = (cyc == repulse_at);
      if (oValid && iReady) begin
        chk("stream_word", {oData, oBank, oAddr, oLast},
            {word_of(mode, got / NW, got % NW), 4'(got / NW), 9'(got % NW), got == TOTAL - 1});
        got++;
      end
      tick;
      cyc++;
    end
    iStart = 1'b0;
  endtask

  initial begin
    int got, cyc, base, dbase;
    logic bad;
    rstn = 1'b0; iStart = 1'b0; iReady = 1'b0; iStart2 = 1'b0; iReady2 = 1'b0;
    repeat (2) tick;
    chk("rst_enb", o_enb, 0);
    chk("rst_addrb", o_addrb, 0);
    chk("rst_out", {oValid, oBank, oAddr, oLast, oBusy, oDone}, 0);
    chk("rst_data", oData, 0);
    rstn = 1'b1;
    repeat (2) tick;

    // 1: bank pattern, iReady held high
    mode = 0; iReady = 1'b1; iStart = 1'b1;
    tick;
    iStart = 1'b0;
    chk("t1_enb_k", o_enb, 16'h0001);
    chk("t1_addrb_k", o_addrb, 0);
    chk("t1_busy", oBusy, 1);
    chk("t1_valid_k", oValid, 0);
    tick;
    chk("t1_valid_k1", oValid, 0);
    chk("t1_addrb_k1", o_addrb, 1);
    tick;
    chk("t1_valid_k2", oValid, 1);
    chk("t1_first", {oData, oBank, oAddr}, {128'hF0E0_D0C0_B0A0_9080_7060_5040_3020_1000, 4'd0, 9'd0});
    run_stream(0, TOTAL, -1, got, cyc);
    chk("t1_count", got, TOTAL);
    chk("t1_cycles", cyc, TOTAL);
    chk("t1_done", oDone, 1);
    chk("t1_busy_off", oBusy, 0);
    tick;
    chk("t1_done_pulse", oDone, 0);

    // 2: {bank,addr} data, random backpressure
    mode = 1; iStart = 1'b1;
    tick;
    iStart = 1'b0;
    run_stream(1, TOTAL, -1, got, cyc);
    chk("t2_count", got, TOTAL);
    chk("t2_done", oDone, 1);
    chk("t2_credit", max_out <= 4, 1);
    tick;

    // 3: consumer stalled for 20 cycles after start
    iReady = 1'b0; base = issued; iStart = 1'b1;
    tick;
    iStart = 1'b0;
    repeat (19) tick;
    chk("t3_issued", issued - base, 4);
    chk("t3_enb_idle", o_enb, 0);
    chk("t3_valid", oValid, 1);
    chk("t3_head", {oData, oBank, oAddr}, {word_of(1, 0, 0), 4'd0, 9'd0});
    chk("t3_credit_full", max_out, 4);
    run_stream(0, TOTAL, -1, got, cyc);
    chk("t3_count", got, TOTAL);
    chk("t3_done", oDone, 1);
    tick;

    // 4: iStart re-pulsed mid-run is ignored
    iStart = 1'b1;
    tick;
    iStart = 1'b0;
    dbase = done_cnt;
    run_stream(1, TOTAL, 40, got, cyc);
    chk("t4_count", got, TOTAL);
    repeat (2) tick;
    chk("t4_single_done", done_cnt - dbase, 1);
    chk("t4_idle", {oBusy, oValid, o_enb}, 0);

    // 5: reset after 300 words, then restart
    mode = 0; iReady = 1'b1; iStart = 1'b1;
    tick;
    iStart = 1'b0;
    run_stream(0, 300, -1, got, cyc);
    chk("t5_partial", got, 300);
    rstn = 1'b0;
    #1;
    chk("t5_abort_ctl", {o_enb, o_addrb, oValid, oBank, oAddr, oLast, oBusy, oDone}, 0);
    chk("t5_abort_data", oData, 0);
    tick;
    rstn = 1'b1;
    bad = 1'b0;
    repeat (10) begin
      tick;
      if (o_enb != '0 || oValid) bad = 1'b1;
    end
    chk("t5_quiet", bad, 0);
    iStart = 1'b1;
    tick;
    iStart = 1'b0;
    run_stream(0, TOTAL, -1, got, cyc);
    chk("t5_restart_count", got, TOTAL);
    chk("t5_done", oDone, 1);
    tick;

    // 6: NUM_BANK=2, NUM_WORDS=1, READ_LAT=2
    iReady2 = 1'b1; iStart2 = 1'b1;
    tick;
    iStart2 = 1'b0;
    chk("t6_busy", oBusy2, 1);
    chk("t6_valid_k", oValid2, 0);
    tick;
    chk("t6_valid_k1", oValid2, 0);
    tick;
    chk("t6_valid_k2", oValid2, 0);
    tick;
    chk("t6_word0", {oValid2, oData2, oBank2, oAddr2, oLast2}, {1'b1, word_of(0, 0, 0), 4'd0, 9'd0, 1'b0});
    tick;
    chk("t6_word1", {oValid2, oData2, oBank2, oAddr2, oLast2}, {1'b1, word_of(0, 1, 0), 4'd1, 9'd0, 1'b1});
    chk("t6_no_early_done", oDone2, 0);
    tick;
    chk("t6_done", {oDone2, oValid2, oBusy2}, 3'b100);
    tick;
    chk("t6_done_pulse", oDone2, 0);

    chk("final_credit", max_out <= 4, 1);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/fmap_bram_reader.md
Name: fmap_bram_reader

Overview:
- Read-side sequencer for the 16-bank feature-map BRAM array that the test-write port (ena/addra/wea/dia) fills.
- On iStart, walks every bank and address through BRAM port B, absorbs the fixed read latency, and streams 128-bit words with bank/address tags to the layer datapath over a valid/ready handshake.
- Sits between the BRAM array and layer00-style compute blocks; the first consumer is the parsing/unpack stage.

Parameters:
NUM_BANK, 16, number of BRAM banks; o_enb width.
ADDR_W, 9, BRAM address width.
NUM_WORDS, 128, words read per bank, addresses 0..NUM_WORDS-1; legal range 1..2^ADDR_W.
DATA_W, 128, BRAM word width.
READ_LAT, 1, cycles from BRAM sampling o_enb/o_addrb to i_dob valid.
FIFO_DEPTH, 4, output buffer entries; must be >= READ_LAT+2.

Ports:
clk  in  1  clock
rstn  in  1  asynchronous active-low reset
iStart  in  1  start pulse/level; sampled only while idle
o_enb  out  NUM_BANK  one-hot port-B enable, registered
o_addrb  out  ADDR_W  port-B read address, registered
i_dob  in  DATA_W  read data of the enabled bank (muxed externally), valid READ_LAT cycles after BRAM samples o_enb
oData  out  DATA_W  FIFO head word
oBank  out  4  bank index of oData
oAddr  out  ADDR_W  address of oData
oLast  out  1  oData is the final word (bank NUM_BANK-1, addr NUM_WORDS-1)
oValid  out  1  oData/oBank/oAddr/oLast valid
iReady  in  1  consumer accepts; handshake = oValid & iReady
oBusy  out  1  high from iStart acceptance to oDone
oDone  out  1  one-cycle pulse after the last handshake

Behaviour:
- Reset (async assert, synchronous release): state IDLE; o_enb=0, o_addrb=0, oValid=0, oData=0, oBank=0, oAddr=0, oLast=0, oBusy=0, oDone=0; FIFO and in-flight tracker cleared.
- FSM states: IDLE -> ISSUE -> DRAIN -> DONE -> IDLE.
- IDLE: iStart=1 at edge k -> ISSUE. bank_cnt=0, addr_cnt=0, oBusy=1 after edge k.
- ISSUE: issue a read each cycle that satisfies fifo_count + inflight - pop < FIFO_DEPTH, where pop = oValid&iReady in the current cycle.
  - Issuing drives o_enb=1<<bank_cnt and o_addrb=addr_cnt on the next edge. Otherwise o_enb=0 (o_addrb holds).
  - Order is bank-major: addr 0..NUM_WORDS-1 of bank 0, then bank 1, ... up to bank NUM_BANK-1. This matches the write-fill order.
  - After issuing bank NUM_BANK-1 / addr NUM_WORDS-1 -> DRAIN; o_enb=0 from the following cycle.
- Tag pipeline: a READ_LAT+1-deep shift register carries {valid, bank, addr, last} alongside each read. When the tag emerges, i_dob plus the tag are pushed into the FIFO.
- Latency: a read issued at edge k+0 (first read issued at the iStart-accepting edge) appears on the BRAM pins after edge k. BRAM samples at edge k+1. The word is pushed at edge k+1+READ_LAT. With READ_LAT=1, oValid is high after edge k+2.
- Throughput: 1 word/cycle while iReady=1. iReady=0 stalls issue once credits are exhausted. Words are never dropped or duplicated, and the FIFO never overflows.
- Output: oData/tags are the FIFO head. They remain stable while oValid=1 and iReady=0.
- Simultaneous push and pop on a full FIFO is legal; the count is unchanged.
- DRAIN: waits until inflight=0 and the FIFO is empty after the oLast handshake -> DONE.
- DONE: oDone=1 for one cycle, oBusy=0 -> IDLE.
- iStart while not IDLE is ignored.
- rstn low mid-operation aborts immediately. In-flight BRAM data returning after release is discarded, because the tracker was cleared.
- bank_cnt wraps only by the ISSUE -> DRAIN transition; addr_cnt wraps to 0 on bank increment.

Decomposition:
- Shared package fmap_pkg holds constants NUM_BANK, ADDR_W, DATA_W, BANK_W=$clog2(NUM_BANK), and the tag struct {bank, addr, last}.
- Sub-module sync_fifo_tagged: parameterized synchronous FIFO (DEPTH, width DATA_W+tag) with count output, used as the output buffer.

Test Plan:
- Fill bank b with 128'hF{b}E{b}_...pattern (bank0 = 128'hF0E0_D0C0_B0A0_9080_7060_5040_3020_1000), iReady=1, iStart pulse.
  - First oValid occurs 2 cycles after the start edge with oData=bank0 pattern, oBank=0, oAddr=0.
  - 2048 handshakes in 2048 consecutive cycles; oLast only on oBank=15/oAddr=127; oDone one cycle later.
- Distinct per-address data (word = {bank, addr} replicated), iReady random 50%.
  - Received sequence is exactly bank-major 0..2047 with no gaps or repeats.
  - o_enb is never asserted when fifo_count + inflight would exceed 4.
- iReady=0 for 20 cycles after start.
  - Exactly 4 reads issued, then o_enb=0, oValid=1, and oData held at bank0/addr0.
  - Releasing iReady resumes the sequence in order.
- iStart re-pulsed during ISSUE: no effect; the count still ends at 2048 with a single oDone.
- rstn asserted after 300 words: all outputs return to reset values at once.
  - After release with no iStart, o_enb and oValid stay 0.
  - A new iStart restarts from bank0/addr0.
- Parameter override NUM_BANK=2, NUM_WORDS=1, READ_LAT=2: 2 words (bank0/addr0, bank1/addr0), first oValid 3 cycles after start, oLast on the second.
